// File: rtl/cia_tod_primitives.sv
// CIA time-of-day primitives: a chainable BCD digit updater (load/increment/wrap/carry)
// and a strobe-gated falling-edge detector for the TOD pin.
module cia_tod_primitives #(
    parameter  int MAX = 9,
    localparam int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         res,
    // edge detector
    input  logic         phi2_dn,
    input  logic         signal,
    output logic         trigger,
    // digit updater
    input  logic         we,
    input  logic [W-1:0] wdata,
    input  logic [W-1:0] cur,
    input  logic         cin,
    output logic [W-1:0] next,
    output logic         cout
);

    logic prev_q;
    logic trig_q;

    // Write wins over carry; out-of-range digits count on in binary without carrying.
    always_comb begin
        next = cur;
        cout = 1'b0;
        if (we) begin
            next = wdata;
        end else if (cin) begin
            if (cur == W'(MAX)) begin
                next = '0;
                cout = 1'b1;
            end else begin
                next = cur + W'(1);
            end
        end
    end

    // prev resets low, so a line already low at reset release never triggers.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            prev_q <= 1'b0;
            trig_q <= 1'b0;
        end else if (phi2_dn) begin
            prev_q <= signal;
            trig_q <= prev_q & ~signal;
        end
    end

    assign trigger = trig_q;

endmodule

// File: tb/tb_cia_tod_primitives.sv
module tb_cia_tod_primitives;

    logic clk = 1'b0;
    logic res, phi2, sig;
    always #5 clk = ~clk;

    // MAX=9 instance (also carries the edge detector under test)
    logic       we9, cin9, cout9, trig9;
    logic [3:0] wd9, cur9, nx9;
    // MAX=5 instance
    logic       we5, cin5, cout5, trig5;
    logic [2:0] wd5, cur5, nx5;
    // MAX=1 instance
    logic       we1, cin1, cout1, trig1;
    logic [0:0] wd1, cur1, nx1;

    cia_tod_primitives #(.MAX(9)) u9 (
        .clk(clk), .res(res), .phi2_dn(phi2), .signal(sig), .trigger(trig9),
        .we(we9), .wdata(wd9), .cur(cur9), .cin(cin9), .next(nx9), .cout(cout9));
    cia_tod_primitives #(.MAX(5)) u5 (
        .clk(clk), .res(res), .phi2_dn(phi2), .signal(sig), .trigger(trig5),
        .we(we5), .wdata(wd5), .cur(cur5), .cin(cin5), .next(nx5), .cout(cout5));
    cia_tod_primitives #(.MAX(1)) u1 (
        .clk(clk), .res(res), .phi2_dn(phi2), .signal(sig), .trigger(trig1),
        .we(we1), .wdata(wd1), .cur(cur1), .cin(cin1), .next(nx1), .cout(cout1));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int         inst;   // 9, 5 or 1
        logic       we;
        logic [3:0] wdata;
        logic [3:0] cur;
        logic       cin;
        logic [3:0] exp_next;
        logic       exp_cout;
    } dvec_t;

    dvec_t vt[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One strobe period: strobe on the first clk, three quiet clks after.
    task automatic strobe(input logic s, input logic exp, input string name);
        sig  = s;
        phi2 = 1'b1;
        tick();
        chk(name, {3'b0, trig9}, {3'b0, exp});
        phi2 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk({name, "_hold"}, {3'b0, trig9}, {3'b0, exp});
        end
    endtask

    initial begin
        logic [5:0] pat;
        logic [5:0] pexp;
        res = 1'b1; phi2 = 1'b0; sig = 1'b0;
        we9 = 0; cin9 = 0; wd9 = 0; cur9 = 0;
        we5 = 0; cin5 = 0; wd5 = 0; cur5 = 0;
        we1 = 0; cin1 = 0; wd1 = 0; cur1 = 0;

        // ---- digit updater vectors ----
        vt.push_back('{9, 0, 4'd0,  4'd9,  1, 4'd0,  1});
        vt.push_back('{9, 0, 4'd0,  4'd4,  1, 4'd5,  0});
        vt.push_back('{9, 0, 4'd0,  4'd7,  0, 4'd7,  0});
        vt.push_back('{9, 0, 4'd0,  4'd15, 1, 4'd0,  0});
        vt.push_back('{9, 0, 4'd0,  4'd10, 1, 4'd11, 0});
        vt.push_back('{9, 1, 4'd12, 4'd9,  1, 4'd12, 0});
        vt.push_back('{9, 1, 4'd3,  4'd2,  0, 4'd3,  0});
        vt.push_back('{9, 0, 4'd5,  4'd0,  1, 4'd1,  0});
        vt.push_back('{9, 0, 4'd9,  4'd9,  0, 4'd9,  0});
        vt.push_back('{5, 0, 4'd0,  4'd5,  1, 4'd0,  1});
        vt.push_back('{5, 1, 4'd3,  4'd5,  1, 4'd3,  0});
        vt.push_back('{5, 0, 4'd0,  4'd2,  1, 4'd3,  0});
        vt.push_back('{5, 0, 4'd0,  4'd7,  1, 4'd0,  0});
        vt.push_back('{5, 0, 4'd0,  4'd6,  1, 4'd7,  0});
        vt.push_back('{1, 0, 4'd0,  4'd1,  1, 4'd0,  1});
        vt.push_back('{1, 0, 4'd0,  4'd0,  1, 4'd1,  0});
        vt.push_back('{1, 1, 4'd0,  4'd1,  1, 4'd0,  0});
        vt.push_back('{1, 0, 4'd0,  4'd1,  0, 4'd1,  0});

        foreach (vt[i]) begin
            case (vt[i].inst)
                9: begin we9 = vt[i].we; wd9 = vt[i].wdata; cur9 = vt[i].cur; cin9 = vt[i].cin; end
                5: begin we5 = vt[i].we; wd5 = vt[i].wdata[2:0]; cur5 = vt[i].cur[2:0]; cin5 = vt[i].cin; end
                default: begin we1 = vt[i].we; wd1 = vt[i].wdata[0:0]; cur1 = vt[i].cur[0:0]; cin1 = vt[i].cin; end
            endcase
            #1;
            case (vt[i].inst)
                9: begin
                    chk($sformatf("d9_next[%0d]", i), nx9, vt[i].exp_next);
                    chk($sformatf("d9_cout[%0d]", i), {3'b0, cout9}, {3'b0, vt[i].exp_cout});
                end
                5: begin
                    chk($sformatf("d5_next[%0d]", i), {1'b0, nx5}, vt[i].exp_next);
                    chk($sformatf("d5_cout[%0d]", i), {3'b0, cout5}, {3'b0, vt[i].exp_cout});
                end
                default: begin
                    chk($sformatf("d1_next[%0d]", i), {3'b0, nx1}, vt[i].exp_next);
                    chk($sformatf("d1_cout[%0d]", i), {3'b0, cout1}, {3'b0, vt[i].exp_cout});
                end
            endcase
        end

        // ---- edge detector ----
        tick();
        chk("rst_trigger", {3'b0, trig9}, 4'd0);
        // strobes held while in reset must not advance state
        sig = 1'b1; phi2 = 1'b1; tick(); sig = 1'b0; tick();
        chk("rst_hold_trigger", {3'b0, trig9}, 4'd0);
        phi2 = 1'b0; sig = 1'b1;
        tick();
        res = 1'b0;
        tick();

        pat  = 6'b110010;   // sampled MSB first: 1,1,0,0,1,0
        pexp = 6'b001001;
        for (int i = 5; i >= 0; i--)
            strobe(pat[i], pexp[i], $sformatf("edge_seq%0d", 5 - i));

        // low glitch between strobes is never sampled
        strobe(1'b1, 1'b0, "glitch_pre");
        sig = 1'b0; tick(); sig = 1'b1; tick();
        strobe(1'b1, 1'b0, "glitch_post");

        // reset released with line already low: no trigger until high then low
        res = 1'b1; #2; res = 1'b0;
        strobe(1'b0, 1'b0, "low_at_rst0");
        strobe(1'b0, 1'b0, "low_at_rst1");
        strobe(1'b1, 1'b0, "after_rst_hi");
        strobe(1'b0, 1'b1, "after_rst_fall");

        // async reset mid-pulse, between clk edges
        sig = 1'b0; phi2 = 1'b1;
        @(negedge clk);
        res = 1'b1;
        #1;
        chk("async_clear", {3'b0, trig9}, 4'd0);
        @(negedge clk);
        res = 1'b0;
        // restart from prev=0: low line gives nothing
        tick();
        chk("post_async_low", {3'b0, trig9}, 4'd0);
        phi2 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
